// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared state, stack-op and requester-ID encodings for mem_port_arbiter
package mem_arb_pkg;

    localparam int DATA_W = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } arb_state_t;

    typedef enum logic [1:0] {
        SOP_PUSH    = 2'b00,
        SOP_POP     = 2'b01,
        SOP_SWAP    = 2'b10,
        SOP_ILLEGAL = 2'b11
    } s_op_t;

    // Requester IDs double as bit positions in the request/grant vectors.
    typedef enum logic [1:0] {
        ID_FETCH = 2'd0,
        ID_DATA  = 2'd1,
        ID_STACK = 2'd2
    } req_id_t;

    function automatic req_id_t next_id(req_id_t id);
        case (id)
            ID_FETCH: return ID_DATA;
            ID_DATA:  return ID_STACK;
            default:  return ID_FETCH;
        endcase
    endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// rtl/mem_arb_pick.sv - winner selection, fixed stack>data>fetch or round-robin when MEM_ARB_RR_EN is defined
module mem_arb_pick
    import mem_arb_pkg::*;
(
    input  logic [2:0] req,
    input  req_id_t    ptr,
    output logic [2:0] gnt
);

`ifdef MEM_ARB_RR_EN
    // Search starts at the pointer and wraps fetch -> data -> stack.
    always_comb begin
        gnt = 3'b000;
        case (ptr)
            ID_DATA:  gnt = req[1] ? 3'b010 : req[2] ? 3'b100 : req[0] ? 3'b001 : 3'b000;
            ID_STACK: gnt = req[2] ? 3'b100 : req[0] ? 3'b001 : req[1] ? 3'b010 : 3'b000;
            default:  gnt = req[0] ? 3'b001 : req[1] ? 3'b010 : req[2] ? 3'b100 : 3'b000;
        endcase
    end
`else
    logic unused_ptr;
    assign unused_ptr = ^ptr;

    always_comb begin
        gnt = 3'b000;
        if (req[2])      gnt = 3'b100;
        else if (req[1]) gnt = 3'b010;
        else if (req[0]) gnt = 3'b001;
    end
`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - three-port (fetch/data/stack) single-outstanding memory arbiter; MEM_ARB_RR_EN selects round-robin
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W    = 16,
    parameter int RD_LAT    = 2,
    parameter int STK_DEPTH = 128
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              f_req,
    input  logic [ADDR_W-1:0] f_addr,
    output logic              f_gnt,
    output logic              f_valid,
    output logic [DATA_W-1:0] f_rdata,

    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_valid,
    output logic              d_err,
    output logic [DATA_W-1:0] d_rdata,

    input  logic              s_req,
    input  logic [1:0]        s_op,
    input  logic [DATA_W-1:0] s_wdata,
    output logic              s_gnt,
    output logic              s_valid,
    output logic              s_err,
    output logic [DATA_W-1:0] s_rdata,

    output logic [ADDR_W-1:0] m_raddr0,
    output logic              m_wen,
    output logic [ADDR_W-2:0] m_waddr,
    output logic [DATA_W-1:0] m_wdata,
    output logic              m_push,
    output logic              m_pop,
    output logic              m_swap,
    output logic [DATA_W-1:0] m_pushorswap_data,

    input  logic [DATA_W-1:0] m_rdata0,
    input  logic [DATA_W-1:0] m_out
);

    localparam int DEPTH_W = $clog2(STK_DEPTH + 1);

    arb_state_t         state;
    req_id_t            ptr;
    req_id_t            cur_id;
    req_id_t            win_id;
    logic               cur_rd;
    logic               cur_err;
    logic               cur_long;
    logic [7:0]         wait_cnt;
    logic [DEPTH_W-1:0] depth;
    logic [2:0]         pick_gnt;
    logic               finish;
    logic [DATA_W-1:0]  f_hold;
    logic [DATA_W-1:0]  d_hold;
    logic [DATA_W-1:0]  s_hold;

    mem_arb_pick u_pick (
        .req (3'({s_req, d_req, f_req})),
        .ptr (ptr),
        .gnt (pick_gnt)
    );

    always_comb begin
        win_id = ID_FETCH;
        if (pick_gnt[2])      win_id = ID_STACK;
        else if (pick_gnt[1]) win_id = ID_DATA;
    end

    assign finish = (state == ISSUE && !(cur_long && RD_LAT > 1)) ||
                    (state == WAIT && wait_cnt == 8'd0);

    // Read data passes straight through in its valid cycle, then the last value is held.
    assign f_rdata = f_valid            ? m_rdata0 : f_hold;
    assign d_rdata = (d_valid && cur_rd) ? m_rdata0 : d_hold;
    assign s_rdata = (s_valid && cur_rd) ? m_out    : s_hold;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state             <= IDLE;
            ptr               <= ID_FETCH;
            cur_id            <= ID_FETCH;
            cur_rd            <= 1'b0;
            cur_err           <= 1'b0;
            cur_long          <= 1'b0;
            wait_cnt          <= '0;
            depth             <= '0;
            f_gnt             <= 1'b0;
            d_gnt             <= 1'b0;
            s_gnt             <= 1'b0;
            f_valid           <= 1'b0;
            d_valid           <= 1'b0;
            s_valid           <= 1'b0;
            d_err             <= 1'b0;
            s_err             <= 1'b0;
            m_raddr0          <= '0;
            m_wen             <= 1'b0;
            m_waddr           <= '0;
            m_wdata           <= '0;
            m_push            <= 1'b0;
            m_pop             <= 1'b0;
            m_swap            <= 1'b0;
            m_pushorswap_data <= '0;
            f_hold            <= '0;
            d_hold            <= '0;
            s_hold            <= '0;
        end else begin
            f_gnt             <= 1'b0;
            d_gnt             <= 1'b0;
            s_gnt             <= 1'b0;
            f_valid           <= 1'b0;
            d_valid           <= 1'b0;
            s_valid           <= 1'b0;
            d_err             <= 1'b0;
            s_err             <= 1'b0;
            m_raddr0          <= '0;
            m_wen             <= 1'b0;
            m_waddr           <= '0;
            m_wdata           <= '0;
            m_push            <= 1'b0;
            m_pop             <= 1'b0;
            m_swap            <= 1'b0;
            m_pushorswap_data <= '0;

            if (f_valid)           f_hold <= m_rdata0;
            if (d_valid && cur_rd) d_hold <= m_rdata0;
            if (s_valid && cur_rd) s_hold <= m_out;

            case (state)
                IDLE: begin
                    if (|pick_gnt) begin
                        state    <= ISSUE;
                        cur_id   <= win_id;
                        ptr      <= next_id(win_id);
                        cur_rd   <= 1'b0;
                        cur_err  <= 1'b0;
                        cur_long <= 1'b0;
                        {s_gnt, d_gnt, f_gnt} <= pick_gnt;
                        case (win_id)
                            ID_FETCH: begin
                                m_raddr0 <= f_addr;
                                cur_rd   <= 1'b1;
                                cur_long <= 1'b1;
                            end
                            ID_DATA: begin
                                if (!d_we) begin
                                    m_raddr0 <= d_addr;
                                    cur_rd   <= 1'b1;
                                    cur_long <= 1'b1;
                                end else if (d_addr[0]) begin
                                    cur_err <= 1'b1;
                                end else begin
                                    m_wen   <= 1'b1;
                                    m_waddr <= d_addr[ADDR_W-1:1];
                                    m_wdata <= d_wdata;
                                end
                            end
                            default: begin
                                case (s_op_t'(s_op))
                                    SOP_PUSH: begin
                                        if (depth == DEPTH_W'(STK_DEPTH)) begin
                                            cur_err <= 1'b1;
                                        end else begin
                                            m_push            <= 1'b1;
                                            m_pushorswap_data <= s_wdata;
                                            depth             <= depth + DEPTH_W'(1);
                                        end
                                    end
                                    SOP_POP: begin
                                        if (depth == '0) begin
                                            cur_err <= 1'b1;
                                        end else begin
                                            m_pop  <= 1'b1;
                                            cur_rd <= 1'b1;
                                            depth  <= depth - DEPTH_W'(1);
                                        end
                                    end
                                    SOP_SWAP: begin
                                        if (depth == '0) begin
                                            cur_err <= 1'b1;
                                        end else begin
                                            m_swap            <= 1'b1;
                                            m_pushorswap_data <= s_wdata;
                                            cur_rd            <= 1'b1;
                                        end
                                    end
                                    default: cur_err <= 1'b1;
                                endcase
                            end
                        endcase
                    end
                end
                ISSUE: begin
                    if (cur_long && RD_LAT > 1) begin
                        wait_cnt <= 8'(RD_LAT - 2);
                        state    <= WAIT;
                    end else begin
                        state <= IDLE;
                    end
                end
                WAIT: begin
                    if (wait_cnt == 8'd0) state <= IDLE;
                    else                  wait_cnt <= wait_cnt - 8'd1;
                end
                default: state <= IDLE;
            endcase

            if (finish) begin
                f_valid <= (cur_id == ID_FETCH);
                d_valid <= (cur_id == ID_DATA);
                s_valid <= (cur_id == ID_STACK);
                d_err   <= (cur_id == ID_DATA)  && cur_err;
                s_err   <= (cur_id == ID_STACK) && cur_err;
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - transaction-model checked bench for mem_port_arbiter (directed + random)
module tb_mem_port_arbiter;

    localparam int RD_LAT    = 2;
    localparam int STK_DEPTH = 128;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        f_req, d_req, d_we, s_req;
    logic [15:0] f_addr, d_addr, d_wdata, s_wdata, m_rdata0, m_out;
    logic [1:0]  s_op;
    logic        f_gnt, f_valid, d_gnt, d_valid, d_err, s_gnt, s_valid, s_err;
    logic [15:0] f_rdata, d_rdata, s_rdata;
    logic [15:0] m_raddr0, m_wdata, m_pushorswap_data;
    logic [14:0] m_waddr;
    logic        m_wen, m_push, m_pop, m_swap;

    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_W(16), .RD_LAT(RD_LAT), .STK_DEPTH(STK_DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .f_req(f_req), .f_addr(f_addr), .f_gnt(f_gnt), .f_valid(f_valid), .f_rdata(f_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_valid(d_valid), .d_err(d_err), .d_rdata(d_rdata),
        .s_req(s_req), .s_op(s_op), .s_wdata(s_wdata),
        .s_gnt(s_gnt), .s_valid(s_valid), .s_err(s_err), .s_rdata(s_rdata),
        .m_raddr0(m_raddr0), .m_wen(m_wen), .m_waddr(m_waddr), .m_wdata(m_wdata),
        .m_push(m_push), .m_pop(m_pop), .m_swap(m_swap), .m_pushorswap_data(m_pushorswap_data),
        .m_rdata0(m_rdata0), .m_out(m_out)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Transaction model: one pending transaction, its grant cycle and completion cycle.
    bit          busy;
    int          p_id, g_cyc, v_cyc, granted_id;
    bit          p_err, p_rd;
    logic [15:0] x_raddr, x_wdata, x_psd;
    logic [14:0] x_waddr;
    bit          x_wen, x_push, x_pop, x_swap;
    logic [15:0] h_f, h_d, h_s;
    int          depth, last_id;
    logic [15:0] mem_rd, mem_out;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        busy = 0; depth = 0; last_id = 2;
        h_f = '0; h_d = '0; h_s = '0;
    endtask

    task automatic model_edge();
        bit [2:0] rq;
        int       w;
        granted_id = -1;
        if (!rst_n) begin
            model_reset();
            return;
        end
        if (busy) return;
        rq = {s_req, d_req, f_req};
        if (rq == 3'b000) return;
`ifdef MEM_ARB_RR_EN
        w = -1;
        for (int k = 1; k <= 3; k++)
            if (w < 0 && rq[(last_id + k) % 3]) w = (last_id + k) % 3;
`else
        w = rq[2] ? 2 : (rq[1] ? 1 : 0);
`endif
        last_id = w; granted_id = w;
        busy = 1; p_id = w; g_cyc = cyc + 1; v_cyc = g_cyc + 1;
        p_err = 0; p_rd = 0;
        x_raddr = '0; x_wdata = '0; x_psd = '0; x_waddr = '0;
        x_wen = 0; x_push = 0; x_pop = 0; x_swap = 0;
        if (w == 0) begin
            x_raddr = f_addr; p_rd = 1; v_cyc = g_cyc + RD_LAT;
        end else if (w == 1) begin
            if (!d_we) begin
                x_raddr = d_addr; p_rd = 1; v_cyc = g_cyc + RD_LAT;
            end else if (d_addr[0]) p_err = 1;
            else begin
                x_wen = 1; x_waddr = d_addr[15:1]; x_wdata = d_wdata;
            end
        end else begin
            case (s_op)
                2'b00: if (depth == STK_DEPTH) p_err = 1;
                       else begin x_push = 1; x_psd = s_wdata; depth++; end
                2'b01: if (depth == 0) p_err = 1;
                       else begin x_pop = 1; p_rd = 1; depth--; end
                2'b10: if (depth == 0) p_err = 1;
                       else begin x_swap = 1; x_psd = s_wdata; p_rd = 1; end
                default: p_err = 1;
            endcase
        end
    endtask

    task automatic check_cycle();
        bit          at_g, at_v;
        logic [15:0] ef, ed, es;
        at_g = busy && (cyc == g_cyc);
        at_v = busy && (cyc == v_cyc);
        chk("gnt",      {s_gnt, d_gnt, f_gnt},       at_g ? (3'b001 << p_id) : 3'b000);
        chk("valid",    {s_valid, d_valid, f_valid}, at_v ? (3'b001 << p_id) : 3'b000);
        chk("err",      {s_err, d_err},              (at_v && p_err) ? ((p_id == 2) ? 2'b10 : 2'b01) : 2'b00);
        chk("m_raddr0", m_raddr0, at_g ? x_raddr : 16'h0);
        chk("m_wen",    m_wen,    at_g ? x_wen : 1'b0);
        chk("m_waddr",  m_waddr,  at_g ? x_waddr : 15'h0);
        chk("m_wdata",  m_wdata,  at_g ? x_wdata : 16'h0);
        chk("m_stack",  {m_push, m_pop, m_swap}, at_g ? {x_push, x_pop, x_swap} : 3'b000);
        chk("m_psdata", m_pushorswap_data, at_g ? x_psd : 16'h0);
        ef = (at_v && p_id == 0)         ? m_rdata0 : h_f;
        ed = (at_v && p_id == 1 && p_rd) ? m_rdata0 : h_d;
        es = (at_v && p_id == 2 && p_rd) ? m_out    : h_s;
        chk("f_rdata", f_rdata, ef);
        chk("d_rdata", d_rdata, ed);
        chk("s_rdata", s_rdata, es);
        if (at_v) begin
            h_f = ef; h_d = ed; h_s = es; busy = 0;
        end
    endtask

    // A requester holds req until it sees its grant, then drops it.
    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
        m_rdata0 = mem_rd;
        m_out    = mem_out;
        @(negedge clk);
        cyc++;
        check_cycle();
        if (granted_id == 0)      f_req = 1'b0;
        else if (granted_id == 1) d_req = 1'b0;
        else if (granted_id == 2) s_req = 1'b0;
    endtask

    task automatic drain();
        for (int k = 0; k < 10 && busy; k++) step();
        chk("drain timeout", busy, 1'b0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0; step();
        rst_n = 1'b1; step();
    endtask

    int n;
    int order [3];
    int r;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        f_req = 0; f_addr = '0; d_req = 0; d_we = 0; d_addr = '0; d_wdata = '0;
        s_req = 0; s_op = '0; s_wdata = '0;
        m_rdata0 = '0; m_out = '0; mem_rd = '0; mem_out = '0;
        model_reset();
        step(); step();
        chk("reset outputs", {f_gnt, d_gnt, s_gnt, f_valid, d_valid, s_valid, d_err, s_err}, 8'h00);
        chk("reset rdata", {f_rdata, d_rdata, s_rdata}, 48'h0);
        rst_n = 1'b1; step();

        // Single fetch
        mem_rd = 16'h3E00; f_req = 1; f_addr = 16'h0100;
        step();
        chk("fetch f_gnt", f_gnt, 1'b1);
        chk("fetch m_raddr0", m_raddr0, 16'h0100);
        step();
        chk("fetch raddr one cycle", m_raddr0, 16'h0000);
        step();
        chk("fetch f_valid", f_valid, 1'b1);
        chk("fetch f_rdata", f_rdata, 16'h3E00);
        step();

        // Simultaneous requests, pointer at fetch after reset
        do_reset();
        f_req = 1; f_addr = 16'h0200;
        d_req = 1; d_we = 0; d_addr = 16'h0040;
        s_req = 1; s_op = 2'b00; s_wdata = 16'h1111;
        n = 0;
        for (int k = 0; k < 20 && n < 3; k++) begin
            step();
            if (f_gnt | d_gnt | s_gnt) begin
                order[n] = s_gnt ? 2 : (d_gnt ? 1 : 0);
                n++;
            end
        end
        chk("arb grant count", n, 3);
`ifdef MEM_ARB_RR_EN
        chk("arb first", order[0], 0);
        chk("arb second", order[1], 1);
        chk("arb third", order[2], 2);
`else
        chk("arb first", order[0], 2);
        chk("arb second", order[1], 1);
        chk("arb third", order[2], 0);
`endif
        drain();

        // Push then pop
        do_reset();
        s_req = 1; s_op = 2'b00; s_wdata = 16'hBEEF;
        step();
        chk("push m_push", m_push, 1'b1);
        chk("push data", m_pushorswap_data, 16'hBEEF);
        step();
        chk("push valid", {s_valid, s_err}, 2'b10);
        mem_out = 16'h5A5A; s_req = 1; s_op = 2'b01;
        step();
        chk("pop m_pop", m_pop, 1'b1);
        step();
        chk("pop valid", {s_valid, s_err}, 2'b10);
        chk("pop s_rdata", s_rdata, 16'h5A5A);
        mem_out = 16'h0000;
        step();
        chk("pop s_rdata held", s_rdata, 16'h5A5A);

        // Rejections: pop at depth 0, push when full, misaligned write
        s_req = 1; s_op = 2'b01;
        step();
        chk("pop0 gnt/no strobe", {s_gnt, m_pop}, 2'b10);
        step();
        chk("pop0 err", {s_valid, s_err}, 2'b11);
        for (int k = 0; k < STK_DEPTH; k++) begin
            s_req = 1; s_op = 2'b00; s_wdata = 16'($urandom);
            step(); step();
        end
        s_req = 1; s_op = 2'b00; s_wdata = 16'h7777;
        step();
        chk("push full no strobe", {s_gnt, m_push}, 2'b10);
        step();
        chk("push full err", {s_valid, s_err}, 2'b11);
        s_req = 1; s_op = 2'b01;
        step();
        chk("pop at full ok", m_pop, 1'b1);
        step();
        chk("pop at full no err", s_err, 1'b0);
        d_req = 1; d_we = 1; d_addr = 16'h0201; d_wdata = 16'hCAFE;
        step();
        chk("misaligned no wen", {d_gnt, m_wen}, 2'b10);
        step();
        chk("misaligned err", {d_valid, d_err}, 2'b11);

        // Reset in the middle of a fetch
        step();
        mem_rd = 16'h1234; f_req = 1; f_addr = 16'h0300;
        step();
        chk("abort f_gnt", f_gnt, 1'b1);
        step();
        rst_n = 1'b0;
        step();
        chk("abort no valid", f_valid, 1'b0);
        chk("abort rdata zero", f_rdata, 16'h0000);
        rst_n = 1'b1;
        step();
        chk("abort still no valid", f_valid, 1'b0);
        f_req = 1; f_addr = 16'h0302;
        step();
        chk("after abort f_gnt", f_gnt, 1'b1);
        drain();

        // Randomized traffic against the model
        for (int k = 0; k < 3000; k++) begin
            rst_n = ($urandom_range(0, 299) != 0);
            if (!f_req) begin
                if ($urandom_range(0, 3) == 0) begin f_req = 1; f_addr = 16'($urandom); end
            end else if ($urandom_range(0, 15) == 0) f_req = 0;
            else if ($urandom_range(0, 3) == 0) f_addr = 16'($urandom);
            if (!d_req) begin
                if ($urandom_range(0, 3) == 0) begin
                    d_req = 1; d_we = 1'($urandom); d_addr = 16'($urandom); d_wdata = 16'($urandom);
                end
            end else if ($urandom_range(0, 15) == 0) d_req = 0;
            else if ($urandom_range(0, 3) == 0) d_addr = 16'($urandom);
            if (!s_req) begin
                if ($urandom_range(0, 3) == 0) begin
                    r = $urandom_range(0, 9);
                    s_req = 1;
                    s_op = (r < 4) ? 2'b00 : (r < 7) ? 2'b01 : (r < 9) ? 2'b10 : 2'b11;
                    s_wdata = 16'($urandom);
                end
            end else if ($urandom_range(0, 15) == 0) s_req = 0;
            mem_rd  = 16'($urandom);
            mem_out = 16'($urandom);
            step();
        end
        rst_n = 1'b1;
        f_req = 0; d_req = 0; s_req = 0;
        step();
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 16, byte address width.
REQ-002 SHALL have parameter RD_LAT, default 2, cycles from memory read command to rdata0 valid.
REQ-003 SHALL have parameter STK_DEPTH, default 128, maximum words held on the stack.
REQ-004 SHALL have port clk  in  1  clock, all logic on rising edge.
REQ-005 SHALL have port rst_n  in  1  reset, synchronous, active-low.
REQ-006 SHALL have ports f_req/f_addr  in  1/16  and f_gnt/f_valid/f_rdata  out  1/1/16: instruction-fetch read requester.
REQ-007 SHALL have ports d_req/d_we/d_addr/d_wdata  in  1/1/16/16  and d_gnt/d_valid/d_err/d_rdata  out  1/1/1/16: data read/write requester.
REQ-008 SHALL have ports s_req/s_op/s_wdata  in  1/2/16  and s_gnt/s_valid/s_err/s_rdata  out  1/1/1/16: stack requester; s_op 00 push, 01 pop, 10 swap, 11 illegal.
REQ-009 SHALL have ports m_raddr0/m_wen/m_waddr/m_wdata  out  16/1/15/16: memory read and write command.
REQ-010 SHALL have ports m_push/m_pop/m_swap/m_pushorswap_data  out  1/1/1/16: memory stack command.
REQ-011 SHALL have ports m_rdata0/m_out  in  16/16: memory read data and stack data.

Function
REQ-012 SHALL use FSM states IDLE, ISSUE, WAIT; at most one transaction outstanding.
REQ-013 SHALL, in IDLE with any req high at edge T, latch the winner and its command fields, enter ISSUE, and pulse that requester's gnt for exactly one cycle (T+1).
REQ-014 SHALL drive the memory command registered, high for exactly cycle T+1 only; all other m_* strobes SHALL be 0.
REQ-015 SHALL arbitrate by fixed priority stack > data > fetch when MEM_ARB_RR_EN is undefined.
REQ-016 SHALL complete a read (fetch, or data with d_we=0) with valid pulse and rdata = m_rdata0 in cycle T+1+RD_LAT (T+3 at default).
REQ-017 SHALL complete a write, push, pop or swap with valid pulse in cycle T+2; pop/swap rdata = m_out.
REQ-018 SHALL return to IDLE in the valid cycle; a new grant MAY issue from the next edge.
REQ-019 SHALL treat a req dropped before gnt as withdrawn; command fields are sampled only at grant.
REQ-020 SHALL track stack depth 0..STK_DEPTH: push +1, pop -1, swap unchanged.
REQ-021 SHALL reject pop or swap at depth 0, push at depth STK_DEPTH, s_op=11, and data write with d_addr[0]=1: gnt pulses, no memory command, valid+err pulse in T+2, depth unchanged.
REQ-022 SHALL drive m_waddr = d_addr[15:1] and m_wdata = d_wdata on an aligned write.
REQ-023 SHALL hold rdata outputs stable from valid until that requester's next valid.

Reset
REQ-024 SHALL, while rst_n=0 at an edge, force state IDLE, depth 0, RR pointer to fetch, and all gnt/valid/err/m_* outputs and rdata to 0.
REQ-025 SHALL abort any in-flight transaction on reset with no valid pulse afterwards.

Configuration
REQ-026 SHALL, when MEM_ARB_RR_EN is defined, arbitrate round-robin: the pointer advances to the requester after the last granted one, order fetch -> data -> stack; without it, fixed priority per REQ-015.

Structure
REQ-027 SHALL place the state enum, s_op encodings and requester-ID enum in package mem_arb_pkg.
REQ-028 SHALL implement winner selection in sub-module mem_arb_pick (fixed or round-robin, 3 requests in, one-hot grant out).

Verification
REQ-029 Single fetch f_addr=16'h0100, m_rdata0=16'h3E00 -> f_gnt at T+1, m_raddr0=16'h0100 for one cycle, f_valid with f_rdata=16'h3E00 at T+3.
REQ-030 f_req, d_req, s_req push all high at the same edge (fixed priority) -> grants stack, data, fetch in that order; with MEM_ARB_RR_EN and pointer at fetch -> fetch, data, stack.
REQ-031 Push 16'hBEEF then pop -> m_push with m_pushorswap_data=16'hBEEF; pop s_valid at T+2 with s_rdata=m_out; depth 1 then 0.
REQ-032 Pop at depth 0, push at depth 128, and data write to 16'h0201 -> err pulses, no m_* strobe, depth unchanged.
REQ-033 Assert rst_n=0 at cycle T+2 of a fetch -> no f_valid, all outputs 0, next request granted normally.
